// File: rtl/irq_pending_latch.sv
// Request synchronizer, edge detector and per-channel pending latch that feeds the 4-to-2 priority encoder.
// Optional build macro IRQ_MASK_EN adds a per-channel mask input that gates events and pending outputs.
module irq_pending_latch #(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_MODE   = 1'b1,
    parameter int OVF_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req_in,
    input  logic             ack,
    input  logic [1:0]       ack_idx,
    input  logic             clr_ovf,
`ifdef IRQ_MASK_EN
    input  logic [3:0]       mask,
`endif
    output logic             d3,
    output logic             d2,
    output logic             d1,
    output logic             d0,
    output logic             any_pend,
    output logic [OVF_W-1:0] ovf_cnt,
    output logic             err_ack
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } chan_state_e;

    localparam int SUM_W = OVF_W + 3;
    localparam logic [SUM_W-1:0] OVF_MAX = SUM_W'({OVF_W{1'b1}});

    logic [3:0]       sync_q [SYNC_STAGES];
    logic [3:0]       s_d_q;
    logic [3:0]       s;
    chan_state_e      state_q [4];
    chan_state_e      state_d [4];
    logic [3:0]       pend_vec;
    logic [3:0]       mask_eff;
    logic [3:0]       ev;
    logic [3:0]       rise;
    logic [3:0]       clr;
    logic [3:0]       lost;
    logic [2:0]       lost_sum;
    logic [SUM_W-1:0] ovf_wide;
    logic [OVF_W-1:0] ovf_q;
    logic [OVF_W-1:0] ovf_d;
    logic             err_q;

`ifdef IRQ_MASK_EN
    assign mask_eff = mask;
`else
    assign mask_eff = 4'b0000;
`endif

    assign s = sync_q[SYNC_STAGES-1];

    // Synchronizer chain and edge history; both start from 0 so reset release never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= 4'b0000;
            end
            s_d_q <= 4'b0000;
        end else begin
            sync_q[0] <= req_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            s_d_q <= s;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            pend_vec[i] = (state_q[i] == PEND);
        end
    end

    // A lost event is a fresh assertion on an already-pending channel that is not being cleared;
    // a held level in level mode is one assertion, so it is never counted twice.
    always_comb begin
        rise = s & ~s_d_q & ~mask_eff;
        ev   = (EDGE_MODE ? (s & ~s_d_q) : s) & ~mask_eff;
        for (int i = 0; i < 4; i++) begin
            clr[i]     = ack && (ack_idx == 2'(i));
            lost[i]    = rise[i] & pend_vec[i] & ~clr[i];
            state_d[i] = state_q[i];
            case (state_q[i])
                IDLE:    if (ev[i]) state_d[i] = PEND;
                PEND:    if (clr[i] && !ev[i]) state_d[i] = IDLE;
                default: state_d[i] = IDLE;
            endcase
        end
    end

    always_comb begin
        lost_sum = {2'b00, lost[0]} + {2'b00, lost[1]} + {2'b00, lost[2]} + {2'b00, lost[3]};
        ovf_wide = SUM_W'(ovf_q) + SUM_W'(lost_sum);
        if (clr_ovf) begin
            ovf_d = '0;
        end else if (ovf_wide > OVF_MAX) begin
            ovf_d = {OVF_W{1'b1}};
        end else begin
            ovf_d = ovf_wide[OVF_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= IDLE;
            end
            ovf_q <= '0;
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
            end
            ovf_q <= ovf_d;
            err_q <= ack && !pend_vec[ack_idx];
        end
    end

    // Masking hides a stored pending bit without discarding it.
    assign {d3, d2, d1, d0} = pend_vec & ~mask_eff;
    assign any_pend         = |(pend_vec & ~mask_eff);
    assign ovf_cnt          = ovf_q;
    assign err_ack          = err_q;

endmodule
